// File: rtl/uart_tx_ctrl_if.sv
// Bundle between a byte producer and the UART transmit sequencer:
// payload/config inputs toward the controller, mux select, serial bit,
// parity bit and busy back out.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [1:0]            MUX_SEL;
   logic                  SER_DATA;
   logic                  PAR_BIT;
   logic                  BUSY;

   // Producer side: drives the payload, observes the frame progress.
   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      input  MUX_SEL, SER_DATA, PAR_BIT, BUSY
   );

   // Controller side.
   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      output MUX_SEL, SER_DATA, PAR_BIT, BUSY
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer. Latches a byte plus parity configuration and walks
// START -> DATA (LSB first) -> optional PARITY -> STOP, one frame bit per
// clock. MUX_SEL and BUSY are decoded from the registered state only; the
// downstream mux adds one cycle of lag which is not compensated here.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic           CLK,
   input  logic           RST,   // synchronous, active-low
   uart_tx_ctrl_if.slave  tx
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
   logic                  par_en_q,  par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  par_bit_q, par_bit_d;
   logic                  accept;
   logic [1:0]            mux_sel;
   logic                  busy;

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         par_bit_q <= par_bit_d;
      end
   end

   // Next-state and datapath update; new payload is only taken in IDLE or STOP.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      par_bit_d = par_bit_q;
      accept    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tx.DATA_VALID) accept = 1'b1;
         end
         S_START: begin
            // Shift register still holds the untouched payload here, so the
            // parity re-derived from the latched copies equals the value
            // loaded on accept; the frame's parity stays tied to its own config.
            par_bit_d = (^shift_q) ^ par_typ_q;
            cnt_d     = '0;
            state_d   = S_DATA;
         end
         S_DATA: begin
            shift_d = shift_q >> 1;
            if (cnt_q >= LAST_CNT) begin
               cnt_d   = '0;
               state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            state_d = S_STOP;
         end
         S_STOP: begin
            if (tx.DATA_VALID) accept  = 1'b1;
            else               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (accept) begin
         shift_d   = tx.P_DATA;
         par_en_d  = tx.PAR_EN;
         par_typ_d = tx.PAR_TYP;
         par_bit_d = (^tx.P_DATA) ^ tx.PAR_TYP;
         state_d   = S_START;
      end
   end

   // Moore output decode from the registered state.
   always_comb begin
      mux_sel = 2'b01;
      busy    = 1'b0;
      case (state_q)
         S_IDLE:   begin mux_sel = 2'b01; busy = 1'b0; end
         S_START:  begin mux_sel = 2'b00; busy = 1'b1; end
         S_DATA:   begin mux_sel = 2'b10; busy = 1'b1; end
         S_PARITY: begin mux_sel = 2'b11; busy = 1'b1; end
         S_STOP:   begin mux_sel = 2'b01; busy = 1'b1; end
         default:  begin mux_sel = 2'b01; busy = 1'b0; end
      endcase
   end

   assign tx.MUX_SEL  = mux_sel;
   assign tx.BUSY     = busy;
   assign tx.SER_DATA = shift_q[0];
   assign tx.PAR_BIT  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: an 8-bit and a 7-bit instance share clock
// and reset. Expected per-cycle outputs are queued when a frame is offered and
// popped every cycle; an empty queue means the instance should sit idle.
module tb_uart_tx_ctrl;

   typedef struct packed {
      logic [63:0] tag;   // short ASCII name of the expected cycle
      logic [4:0]  val;   // {MUX_SEL, BUSY, SER_DATA, PAR_BIT}
      logic [4:0]  mask;  // which of those bits are checked
   } exp_t;

   logic clk;
   logic rst;

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) b8 ();
   uart_tx_ctrl_if #(.DATA_WIDTH(7)) b7 ();

   uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut8 (
      .CLK (clk),
      .RST (rst),
      .tx  (b8)
   );

   uart_tx_ctrl #(.DATA_WIDTH(7), .CNT_WIDTH(4)) u_dut7 (
      .CLK (clk),
      .RST (rst),
      .tx  (b7)
   );

   exp_t q8[$];
   exp_t q7[$];
   logic par8;
   logic par7;
   int   checks;
   int   fails;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue the expected cycles of one frame accepted on the coming edge.
   task automatic push_frame(input int dw, input logic [8:0] d, input logic en,
                             input logic typ, input bit sel7);
      exp_t e;
      logic p;
      p = typ;
      for (int i = 0; i < dw; i++) p = p ^ d[i];
      e = '{tag: "start", val: {2'b00, 1'b1, 1'b0, p}, mask: 5'b11101};
      if (sel7) q7.push_back(e); else q8.push_back(e);
      for (int i = 0; i < dw; i++) begin
         e = '{tag: "data", val: {2'b10, 1'b1, d[i], p}, mask: 5'b11111};
         if (sel7) q7.push_back(e); else q8.push_back(e);
      end
      if (en) begin
         e = '{tag: "parity", val: {2'b11, 1'b1, 1'b0, p}, mask: 5'b11101};
         if (sel7) q7.push_back(e); else q8.push_back(e);
      end
      e = '{tag: "stop", val: {2'b01, 1'b1, 1'b0, p}, mask: 5'b11101};
      if (sel7) q7.push_back(e); else q8.push_back(e);
      if (sel7) par7 = p; else par8 = p;
   endtask

   // Advance one clock and compare both instances at the falling edge.
   task automatic tick();
      exp_t e;
      logic [4:0] obs;
      logic [4:0] ex;
      @(posedge clk);
      @(negedge clk);
      if (q8.size() > 0) e = q8.pop_front();
      else e = '{tag: "idle", val: {2'b01, 1'b0, 1'b0, par8}, mask: 5'b11101};
      obs = {b8.MUX_SEL, b8.BUSY, b8.SER_DATA, b8.PAR_BIT} & e.mask;
      ex  = e.val & e.mask;
      checks++;
      assert (obs === ex) else begin
         fails++;
         $error("FAIL dut8 %0s t=%0t observed mux/busy/ser/par=%b expected=%b", e.tag, $time, obs, ex);
      end
      if (q7.size() > 0) e = q7.pop_front();
      else e = '{tag: "idle", val: {2'b01, 1'b0, 1'b0, par7}, mask: 5'b11101};
      obs = {b7.MUX_SEL, b7.BUSY, b7.SER_DATA, b7.PAR_BIT} & e.mask;
      ex  = e.val & e.mask;
      checks++;
      assert (obs === ex) else begin
         fails++;
         $error("FAIL dut7 %0s t=%0t observed mux/busy/ser/par=%b expected=%b", e.tag, $time, obs, ex);
      end
   endtask

   // Offer one payload for a single cycle; the START cycle is checked here.
   task automatic send8(input logic [7:0] d, input logic en, input logic typ);
      b8.P_DATA     = d;
      b8.PAR_EN     = en;
      b8.PAR_TYP    = typ;
      b8.DATA_VALID = 1'b1;
      push_frame(8, {1'b0, d}, en, typ, 1'b0);
      tick();
      b8.DATA_VALID = 1'b0;
      $display("tx8 data=%h par_en=%0b par_typ=%0b", d, en, typ);
   endtask

   task automatic send7(input logic [6:0] d, input logic en, input logic typ);
      b7.P_DATA     = d;
      b7.PAR_EN     = en;
      b7.PAR_TYP    = typ;
      b7.DATA_VALID = 1'b1;
      push_frame(7, {2'b00, d}, en, typ, 1'b1);
      tick();
      b7.DATA_VALID = 1'b0;
      $display("tx7 data=%h par_en=%0b par_typ=%0b", d, en, typ);
   endtask

   // Run until both queues empty (bounded), then confirm idle for two cycles.
   task automatic drain();
      for (int i = 0; i < 40 && (q8.size() > 0 || q7.size() > 0); i++) tick();
      checks++;
      assert (q8.size() == 0 && q7.size() == 0) else begin
         fails++;
         $error("FAIL drain_timeout observed pending=%0d expected=0", q8.size() + q7.size());
      end
      tick();
      tick();
   endtask

   initial begin
      exp_t e;
      checks = 0;
      fails  = 0;
      par8   = 1'b0;
      par7   = 1'b0;
      rst    = 1'b0;
      b8.P_DATA = '0; b8.DATA_VALID = 1'b0; b8.PAR_EN = 1'b0; b8.PAR_TYP = 1'b0;
      b7.P_DATA = '0; b7.DATA_VALID = 1'b0; b7.PAR_EN = 1'b0; b7.PAR_TYP = 1'b0;

      // Reset state, with DATA_VALID asserted to show reset wins.
      e = '{tag: "reset", val: {2'b01, 1'b0, 1'b0, 1'b0}, mask: 5'b11111};
      q8.push_back(e); q8.push_back(e);
      q7.push_back(e); q7.push_back(e);
      @(negedge clk);
      b8.DATA_VALID = 1'b1; b8.P_DATA = 8'hFF; b8.PAR_TYP = 1'b1;
      tick();
      tick();
      b8.DATA_VALID = 1'b0; b8.P_DATA = 8'h00; b8.PAR_TYP = 1'b0;
      rst = 1'b1;
      tick();
      $display("reset done");

      // 1: plain frame, no parity.
      send8(8'hA5, 1'b0, 1'b0);
      drain();

      // 2: even then odd parity.
      send8(8'hA5, 1'b1, 1'b0);
      drain();
      send8(8'hA5, 1'b1, 1'b1);
      drain();

      // 3: back-to-back, second byte offered during STOP of the first.
      send8(8'h0F, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      send8(8'hF0, 1'b0, 1'b0);
      drain();

      // 4: disturbance on the inputs while DATA is in progress.
      send8(8'hA5, 1'b1, 1'b0);
      tick();
      tick();
      b8.DATA_VALID = 1'b1; b8.P_DATA = 8'hFF; b8.PAR_TYP = 1'b1; b8.PAR_EN = 1'b0;
      tick();
      tick();
      tick();
      b8.DATA_VALID = 1'b0; b8.PAR_TYP = 1'b0;
      drain();

      // 5: reset in the middle of a frame, then a clean frame.
      send8(8'h3C, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b0;
      q8.delete();
      par8 = 1'b0;
      e = '{tag: "midrst", val: {2'b01, 1'b0, 1'b0, 1'b0}, mask: 5'b11111};
      q8.push_back(e);
      tick();
      rst = 1'b1;
      $display("mid-frame reset applied");
      send8(8'h81, 1'b0, 1'b0);
      drain();

      // 6: seven-bit instance, odd parity over all ones.
      send7(7'h7F, 1'b1, 1'b1);
      drain();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
